huffman_encoder: RTL and testbench

HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

---
 rtl/huffman_encoder_pkg.sv | 29 ++
 rtl/huffman_encoder_min2_finder.sv | 41 ++++
 rtl/huffman_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_huffman_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/huffman_encoder_pkg.sv
// Shared types and sizes for the Huffman encoder: FSM state encoding and the
// per-symbol table entry used during collection, merging and code assignment.
package huffman_encoder_pkg;

  localparam int NUM_ENTRIES  = 8;
  localparam int MAX_CODE_LEN = 8;
  localparam int SYM_W        = 8;
  localparam int COUNT_W      = 16;
  localparam int IDX_W        = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_MERGE   = 3'd2,
    S_ASSIGN  = 3'd3,
    S_OUTPUT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic [SYM_W-1:0]        symbol;
    logic [COUNT_W-1:0]      count;
    logic [3:0]              length;
    logic [MAX_CODE_LEN-1:0] code;
    logic [NUM_ENTRIES-1:0]  mask;
    logic                    active;
  } entry_t;

endpackage

// File: rtl/huffman_encoder_min2_finder.sv
// Combinational search for the two smallest active counts; on equal counts the
// lower table index wins, which keeps the merge order deterministic.
module huffman_min2_finder
  import huffman_encoder_pkg::*;
(
  input  logic [COUNT_W-1:0]     counts [NUM_ENTRIES],
  input  logic [NUM_ENTRIES-1:0] active,
  output logic [IDX_W-1:0]       idx_a,
  output logic [IDX_W-1:0]       idx_b
);

  logic               found_a, found_b;
  logic [COUNT_W-1:0] best_a, best_b;

  // NOTE: every variable gets a default before the loops so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idx_a   = '0;
    idx_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    best_a  = '0;
    best_b  = '0;
    // Strict less-than while scanning upward gives the lower index on ties.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (active[i] && (!found_a || counts[i] < best_a)) begin
        found_a = 1'b1;
        best_a  = counts[i];
        idx_a   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (active[i] && IDX_W'(i) != idx_a && (!found_b || counts[i] < best_b)) begin
        found_b = 1'b1;
        best_b  = counts[i];
        idx_b   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_encoder.sv
// Block Huffman encoder: counts up to eight distinct symbols, builds code
// lengths by pairwise merging, then emits canonical codes one per cycle.
module huffman_encoder
  import huffman_encoder_pkg::*;
#(
  parameter int DATA_MSB  = 7,
  parameter int SYM_MAX   = 255,
  parameter int MAX_COUNT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_MSB:0] data_in,
  input  logic              data_enable,
  output logic [DATA_MSB:0] data_out_symbol,
  output logic [3:0]        data_out_length,
  output logic [7:0]        data_out_code,
  output logic              data_out_state,
  output logic [2:0]        out_state
);

  localparam int CNT_W = $clog2(MAX_COUNT) + 1;
  localparam int OUT_W = DATA_MSB + 1;

  state_t             state;
  entry_t             tbl   [NUM_ENTRIES];
  logic [IDX_W-1:0]   order [NUM_ENTRIES];
  logic [3:0]         n_entries;
  logic [CNT_W-1:0]   total;
  logic [2:0]         merges_left;
  logic [NUM_ENTRIES-1:0] assigned;
  logic [3:0]         a_idx, o_idx;
  logic [7:0]         prev_code;
  logic [3:0]         prev_len;

  logic               sym_ok, room, hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [COUNT_W-1:0] cnt_vec [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] act_vec;
  logic [IDX_W-1:0]   idx_a, idx_b, m_lo, m_hi;
  logic [NUM_ENTRIES-1:0] merged_mask;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [11:0]        sel_key;
  logic [8:0]         code_inc;
  logic [7:0]         next_code;

  assign out_state = state;
  assign sym_ok    = (int'(data_in) <= SYM_MAX);
  assign room      = (total < CNT_W'(MAX_COUNT));

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      cnt_vec[k] = tbl[k].count;
      act_vec[k] = tbl[k].active;
      if (!hit && 4'(k) < n_entries && tbl[k].symbol == SYM_W'(data_in)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  huffman_min2_finder u_min2 (
    .counts (cnt_vec),
    .active (act_vec),
    .idx_a  (idx_a),
    .idx_b  (idx_b)
  );

  // The merged node lives at the lower of the two indices.
  assign m_lo        = (idx_a < idx_b) ? idx_a : idx_b;
  assign m_hi        = (idx_a < idx_b) ? idx_b : idx_a;
  assign merged_mask = tbl[m_lo].mask | tbl[m_hi].mask;

  // Next canonical entry: smallest (length, symbol) not yet given a code.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_key   = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (4'(k) < n_entries && !assigned[k] &&
          (!sel_found || {tbl[k].length, tbl[k].symbol} < sel_key)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_key   = {tbl[k].length, tbl[k].symbol};
      end
    end
    code_inc  = {1'b0, prev_code} + 9'd1;
    next_code = (a_idx == 4'd0) ? 8'd0 : 8'(code_inc << (tbl[sel_idx].length - prev_len));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      // NOTE: the table is a small register file that must come up empty after
      // reset, so it is cleared here rather than treated as uninitialised RAM.
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        tbl[k]   <= '0;
        order[k] <= '0;
      end
      n_entries       <= '0;
      total           <= '0;
      merges_left     <= '0;
      assigned        <= '0;
      a_idx           <= '0;
      o_idx           <= '0;
      prev_code       <= '0;
      prev_len        <= '0;
      data_out_symbol <= '0;
      data_out_length <= '0;
      data_out_code   <= '0;
      data_out_state  <= 1'b0;
    end else begin
      data_out_state <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (data_enable && sym_ok) begin
            tbl[0]    <= '{symbol: SYM_W'(data_in), count: COUNT_W'(1), length: 4'd0,
                           code: '0, mask: NUM_ENTRIES'(1), active: 1'b1};
            n_entries <= 4'd1;
            total     <= CNT_W'(1);
            state     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (data_enable) begin
            if (sym_ok && room) begin
              if (hit) begin
                tbl[hit_idx].count <= tbl[hit_idx].count + COUNT_W'(1);
                total              <= total + CNT_W'(1);
              end else if (n_entries < 4'(NUM_ENTRIES)) begin
                tbl[n_entries[IDX_W-1:0]] <= '{symbol: SYM_W'(data_in), count: COUNT_W'(1),
                                              length: 4'd0, code: '0,
                                              mask: NUM_ENTRIES'(1) << n_entries[IDX_W-1:0],
                                              active: 1'b1};
                n_entries <= n_entries + 4'd1;
                total     <= total + CNT_W'(1);
              end
            end
          end else if (n_entries == 4'd1) begin
            tbl[0].length <= 4'd1;
            state         <= S_ASSIGN;
          end else begin
            merges_left <= 3'(n_entries - 4'd1);
            state       <= S_MERGE;
          end
        end
        S_MERGE: begin
          tbl[m_lo].count  <= tbl[m_lo].count + tbl[m_hi].count;
          tbl[m_lo].mask   <= merged_mask;
          tbl[m_hi].active <= 1'b0;
          for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (merged_mask[k]) tbl[k].length <= tbl[k].length + 4'd1;
          end
          merges_left <= merges_left - 3'd1;
          if (merges_left == 3'd1) state <= S_ASSIGN;
        end
        S_ASSIGN: begin
          tbl[sel_idx].code       <= next_code;
          order[a_idx[IDX_W-1:0]] <= sel_idx;
          assigned[sel_idx]       <= 1'b1;
          prev_code               <= next_code;
          prev_len                <= tbl[sel_idx].length;
          a_idx                   <= a_idx + 4'd1;
          if (a_idx == n_entries - 4'd1) begin
            o_idx <= '0;
            state <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (o_idx < n_entries) begin
            data_out_symbol <= OUT_W'(tbl[order[o_idx[IDX_W-1:0]]].symbol);
            data_out_length <= tbl[order[o_idx[IDX_W-1:0]]].length;
            data_out_code   <= tbl[order[o_idx[IDX_W-1:0]]].code;
            data_out_state  <= 1'b1;
            o_idx           <= o_idx + 4'd1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          for (int k = 0; k < NUM_ENTRIES; k++) begin
            tbl[k]   <= '0;
            order[k] <= '0;
          end
          n_entries   <= '0;
          total       <= '0;
          merges_left <= '0;
          assigned    <= '0;
          a_idx       <= '0;
          o_idx       <= '0;
          prev_code   <= '0;
          prev_len    <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: table-driven blocks with a
// scoreboard of expected output entries, plus reset, overflow and ignore cases.
module tb_huffman_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_enable;
  logic [7:0] data_out_symbol;
  logic [3:0] data_out_length;
  logic [7:0] data_out_code;
  logic       data_out_state;
  logic [2:0] out_state;

  always #5 clock = ~clock;

  huffman_encoder dut (
    .clock           (clock),
    .reset           (reset),
    .data_in         (data_in),
    .data_enable     (data_enable),
    .data_out_symbol (data_out_symbol),
    .data_out_length (data_out_length),
    .data_out_code   (data_out_code),
    .data_out_state  (data_out_state),
    .out_state       (out_state)
  );

  typedef struct packed {
    logic [7:0] sym;
    logic [3:0] len;
    logic [7:0] code;
  } exp_t;

  typedef struct {
    string name;
    string din;
    int    n_out;
    exp_t  outs [8];
  } vec_t;

  exp_t sb [$];
  vec_t vecs [8];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;
  int   blk_kraft = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset && data_out_state) begin
      pulse_cnt++;
      blk_kraft += 256 >> data_out_length;
      check("pulse_in_output", 32'(out_state), 32'd4);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_symbol", 32'(data_out_symbol), 32'(e.sym));
        check("out_length", 32'(data_out_length), 32'(e.len));
        check("out_code",   32'(data_out_code),   32'(e.code));
      end
    end
  end

  task automatic add_exp(input int i, input logic [7:0] s, input logic [3:0] l, input logic [7:0] c);
    vecs[i].outs[vecs[i].n_out] = '{sym: s, len: l, code: c};
    vecs[i].n_out++;
  endtask

  task automatic set_vec(input int i, input string name, input string din);
    vecs[i].name  = name;
    vecs[i].din   = din;
    vecs[i].n_out = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    data_enable = 1'b1;
    data_in     = b;
  endtask

  task automatic drive_end();
    @(posedge clock);
    #1;
    data_enable = 1'b0;
  endtask

  task automatic begin_block(input int i);
    for (int j = 0; j < vecs[i].n_out; j++) sb.push_back(vecs[i].outs[j]);
  endtask

  // Waits for DONE then IDLE within a bounded number of cycles.
  task automatic wait_block(input string name, input int start_pulses, input int exp_pulses,
                            input bit check_kraft);
    bit seen_done = 1'b0;
    bit finished  = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clock);
      if (out_state == 3'd5) begin
        seen_done = 1'b1;
        check({name, "_done_dstate"}, 32'(data_out_state), 32'd0);
      end else if (seen_done && out_state == 3'd0) begin
        finished = 1'b1;
      end
    end
    check({name, "_finished"}, 32'(finished), 32'd1);
    check({name, "_pulses"}, 32'(pulse_cnt - start_pulses), 32'(exp_pulses));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    if (check_kraft) check({name, "_kraft"}, 32'(blk_kraft), 32'd256);
  endtask

  task automatic run_vec(input int i);
    int start;
    start     = pulse_cnt;
    blk_kraft = 0;
    begin_block(i);
    for (int j = 0; j < vecs[i].din.len(); j++) drive_byte(vecs[i].din[j]);
    drive_end();
    wait_block(vecs[i].name, start, vecs[i].n_out, vecs[i].n_out > 1);
  endtask

  initial begin
    int start;
    reset       = 1'b1;
    data_in     = '0;
    data_enable = 1'b0;

    set_vec(0, "aaab", "AAAB");
    add_exp(0, 8'h41, 4'd1, 8'h00);
    add_exp(0, 8'h42, 4'd1, 8'h01);
    set_vec(1, "zzz", "ZZZ");
    add_exp(1, 8'h5A, 4'd1, 8'h00);
    set_vec(2, "aabbbccccd", "AABBBCCCCD");
    add_exp(2, 8'h43, 4'd1, 8'b0);
    add_exp(2, 8'h42, 4'd2, 8'b10);
    add_exp(2, 8'h41, 4'd3, 8'b110);
    add_exp(2, 8'h44, 4'd3, 8'b111);
    set_vec(3, "nine", "012345678");
    for (int k = 0; k < 8; k++) add_exp(3, 8'(8'h30 + k), 4'd3, 8'(k));
    set_vec(4, "aab", "AAB");
    add_exp(4, 8'h41, 4'd1, 8'h00);
    add_exp(4, 8'h42, 4'd1, 8'h01);
    set_vec(5, "cd", "CD");
    add_exp(5, 8'h43, 4'd1, 8'h00);
    add_exp(5, 8'h44, 4'd1, 8'h01);
    set_vec(6, "ab", "AB");
    add_exp(6, 8'h41, 4'd1, 8'h00);
    add_exp(6, 8'h42, 4'd1, 8'h01);

    repeat (3) @(posedge clock);
    #1;
    check("rst_state",  32'(out_state),       32'd0);
    check("rst_symbol", 32'(data_out_symbol), 32'd0);
    check("rst_length", 32'(data_out_length), 32'd0);
    check("rst_code",   32'(data_out_code),   32'd0);
    check("rst_dstate", 32'(data_out_state),  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of collecting a block, then a fresh block.
    drive_byte(8'h41);
    drive_byte(8'h41);
    @(posedge clock);
    #1;
    data_enable = 1'b0;
    check("pre_rst_collect", 32'(out_state), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_state",  32'(out_state),       32'd0);
    check("mid_rst_symbol", 32'(data_out_symbol), 32'd0);
    check("mid_rst_length", 32'(data_out_length), 32'd0);
    check("mid_rst_code",   32'(data_out_code),   32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_vec(6);

    // Bytes arriving while merging/assigning are discarded.
    start     = pulse_cnt;
    blk_kraft = 0;
    begin_block(4);
    drive_byte(8'h41);
    drive_byte(8'h41);
    drive_byte(8'h42);
    drive_end();
    repeat (3) drive_byte(8'h43);
    drive_end();
    wait_block("ignore", start, 2, 1'b1);

    // Byte limit: a new symbol after MAX_COUNT accepted bytes is dropped.
    start     = pulse_cnt;
    blk_kraft = 0;
    sb.push_back('{sym: 8'h41, len: 4'd1, code: 8'h00});
    for (int j = 0; j < 1024; j++) drive_byte(8'h41);
    repeat (3) drive_byte(8'h42);
    drive_end();
    wait_block("max_count", start, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
